// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO management slave: frame-decoder state
// encoding, Clause 22 field codes and field widths, plus an address range
// helper used by the write-commit logic.
package mdio_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 5;
   localparam int SKIP_LEN = 18;   // TA + DATA bits of a frame addressed elsewhere

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] ST_PAT   = 2'b01;

   typedef enum logic [3:0] {
      S_PRE,
      S_ST,
      S_OP,
      S_PHY,
      S_REG,
      S_TA,
      S_WDATA,
      S_RDATA,
      S_SKIP
   } mdio_state_e;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input int num_regs);
      return {1'b0, addr} < (ADDR_W+1)'(num_regs);
   endfunction

endpackage

// File: rtl/mdio_peripheral_regfile_if.sv
// MDIO line bundle between a station-management master and a PHY slave.
//   mdio_in  : resolved line value (driven by the master side / bus model)
//   mdio_out : value the slave drives when mdio_oe=1
//   mdio_oe  : slave tristate enable
interface mdio_peripheral_regfile_if;
   logic mdio_in;
   logic mdio_out;
   logic mdio_oe;

   modport slave  (input  mdio_in, output mdio_out, output mdio_oe);
   modport master (output mdio_in, input  mdio_out, input  mdio_oe);
endinterface

// File: rtl/mdio_regbank.sv
// Register bank for the MDIO slave: NUM_REGS x 16-bit registers.
//   clk, reset          : MDC, async active-low reset (bank clears to 0)
//   mdio_we/addr/wdata  : write port from the frame decoder (wins on collision)
//   loc_we/addr/wdata   : write port from the PHY core
//   snap_addr/snap_data : combinational read used to snapshot read frames
//   loc_raddr/loc_rdata : combinational read for the PHY core
// Unimplemented addresses read as 0 and silently ignore writes.
module mdio_regbank
   import mdio_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mdio_we,
   input  logic [ADDR_W-1:0] mdio_addr,
   input  logic [DATA_W-1:0] mdio_wdata,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [DATA_W-1:0] loc_wdata,
   input  logic [ADDR_W-1:0] snap_addr,
   output logic [DATA_W-1:0] snap_data,
   input  logic [ADDR_W-1:0] loc_raddr,
   output logic [DATA_W-1:0] loc_rdata
);

   // Full 32-entry view; entries at or above NUM_REGS are constant zero so
   // the read ports need no separate range check.
   logic [DATA_W-1:0] bank [32];

   for (genvar i = 0; i < 32; i++) begin : g_reg
      if (i < NUM_REGS) begin : g_impl
         logic [DATA_W-1:0] q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               q <= '0;
            end else if (mdio_we && mdio_addr == ADDR_W'(i)) begin
               q <= mdio_wdata;
            end else if (loc_we && loc_addr == ADDR_W'(i)) begin
               q <= loc_wdata;
            end
         end
         assign bank[i] = q;
      end else begin : g_none
         assign bank[i] = '0;
      end
   end

   assign snap_data = bank[snap_addr];
   assign loc_rdata = bank[loc_raddr];

endmodule

// File: rtl/mdio_peripheral_regfile.sv
// Clause 22 MDIO management slave with an internal register bank.
//   clk        : MDC, all sampling on the rising edge
//   reset      : async active-low reset
//   mdio       : MDIO line bundle (slave modport)
//   loc_*      : local write/read port for the PHY core
//   wr_strobe  : one-cycle pulse on an MDIO write commit, wr_addr/wr_data hold
//   frame_err  : one-cycle pulse on a bad ST or OP field
// Build option MDIO_BCAST_EN: PHYAD 0 also matches write frames; read frames
// to PHYAD 0 are skipped so several PHYs never drive at once.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_PRE   | counting preamble 1s; a 0 after enough 1s is ST's first bit
// S_ST    | expecting ST second bit (1)
// S_OP    | shifting 2 opcode bits
// S_PHY   | shifting PHYAD[4:0]
// S_REG   | shifting REGAD[4:0]; address match decided on the last bit
// S_TA    | turnaround; read frames start driving after the first TA bit
// S_WDATA | shifting 16 write-data bits, commit on the last
// S_RDATA | driving TA 0 then DATA[15:0]
// S_SKIP  | ignoring TA+DATA of a frame for another PHY
module mdio_peripheral_regfile
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR = 5'h01,
   parameter int         NUM_REGS = 32,
   parameter int         PRE_LEN  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   mdio_peripheral_regfile_if.slave   mdio,
   input  logic                       loc_we,
   input  logic [ADDR_W-1:0]          loc_addr,
   input  logic [DATA_W-1:0]          loc_wdata,
   input  logic [ADDR_W-1:0]          loc_raddr,
   output logic [DATA_W-1:0]          loc_rdata,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       frame_err
);

   mdio_state_e       state_q, state_d;
   logic [5:0]        pre_cnt_q, pre_cnt_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;   // bits remaining in current field
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] phyad_q, phyad_d;
   logic [ADDR_W-1:0] regad_q, regad_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              out_q, out_d;
   logic              oe_q, oe_d;
   logic              strobe_q, strobe_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ferr_q, ferr_d;

   logic              bank_we;
   logic [ADDR_W-1:0] regad_n;
   logic [DATA_W-1:0] wdata_n;
   logic [DATA_W-1:0] snap_data;
   logic              phy_hit;
   logic              pre_ok;

   assign regad_n = {regad_q[ADDR_W-2:0], mdio.mdio_in};
   assign wdata_n = {sh_q[DATA_W-2:0], mdio.mdio_in};
   // count >= PRE_LEN, phrased so PRE_LEN=0 does not fold to a trivial compare
   assign pre_ok  = (7'(pre_cnt_q) + 7'd1) > 7'(PRE_LEN);

`ifdef MDIO_BCAST_EN
   assign phy_hit = (op_q == OP_WRITE) ? (phyad_q == PHY_ADDR || phyad_q == '0)
                                       : (phyad_q == PHY_ADDR && phyad_q != '0);
`else
   assign phy_hit = (phyad_q == PHY_ADDR);
`endif

   mdio_regbank #(.NUM_REGS(NUM_REGS)) u_bank (
      .clk        (clk),
      .reset      (reset),
      .mdio_we    (bank_we),
      .mdio_addr  (regad_q),
      .mdio_wdata (wdata_n),
      .loc_we     (loc_we),
      .loc_addr   (loc_addr),
      .loc_wdata  (loc_wdata),
      .snap_addr  (regad_n),
      .snap_data  (snap_data),
      .loc_raddr  (loc_raddr),
      .loc_rdata  (loc_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_PRE;
         pre_cnt_q <= '0;
         bit_cnt_q <= '0;
         op_q      <= '0;
         phyad_q   <= '0;
         regad_q   <= '0;
         sh_q      <= '0;
         out_q     <= 1'b1;
         oe_q      <= 1'b0;
         strobe_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         op_q      <= op_d;
         phyad_q   <= phyad_d;
         regad_q   <= regad_d;
         sh_q      <= sh_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         strobe_q  <= strobe_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      op_d      = op_q;
      phyad_d   = phyad_q;
      regad_d   = regad_q;
      sh_d      = sh_q;
      out_d     = out_q;
      oe_d      = oe_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      strobe_d  = 1'b0;
      ferr_d    = 1'b0;
      bank_we   = 1'b0;
      case (state_q)
         S_PRE: begin
            if (mdio.mdio_in) begin
               if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
            end else begin
               pre_cnt_d = '0;
               if (pre_ok) state_d = S_ST;
            end
         end
         S_ST: begin
            if (mdio.mdio_in == ST_PAT[0]) begin
               state_d   = S_OP;
               bit_cnt_d = 5'd1;
            end else begin
               ferr_d    = 1'b1;
               state_d   = S_PRE;
               pre_cnt_d = '0;
            end
         end
         S_OP: begin
            op_d = {op_q[0], mdio.mdio_in};
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else if (op_d == OP_WRITE || op_d == OP_READ) begin
               state_d   = S_PHY;
               bit_cnt_d = 5'(ADDR_W - 1);
            end else begin
               ferr_d    = 1'b1;
               state_d   = S_PRE;
               pre_cnt_d = '0;
            end
         end
         S_PHY: begin
            phyad_d = {phyad_q[ADDR_W-2:0], mdio.mdio_in};
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
               state_d   = S_REG;
               bit_cnt_d = 5'(ADDR_W - 1);
            end
         end
         S_REG: begin
            regad_d = regad_n;
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else if (phy_hit) begin
               state_d   = S_TA;
               bit_cnt_d = 5'd1;
               // Snapshot now so later local writes cannot disturb the read.
               if (op_q == OP_READ) sh_d = snap_data;
            end else begin
               state_d   = S_SKIP;
               bit_cnt_d = 5'(SKIP_LEN - 1);
            end
         end
         S_TA: begin
            if (op_q == OP_READ) begin
               state_d   = S_RDATA;
               bit_cnt_d = 5'(DATA_W);
               oe_d      = 1'b1;
               out_d     = 1'b0;
            end else if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
               state_d   = S_WDATA;
               bit_cnt_d = 5'(DATA_W - 1);
            end
         end
         S_WDATA: begin
            sh_d = wdata_n;
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
               state_d   = S_PRE;
               pre_cnt_d = '0;
               if (addr_in_range(regad_q, NUM_REGS)) begin
                  bank_we  = 1'b1;
                  strobe_d = 1'b1;
                  waddr_d  = regad_q;
                  wdata_d  = wdata_n;
               end
            end
         end
         S_RDATA: begin
            if (bit_cnt_q != '0) begin
               out_d     = sh_q[DATA_W-1];
               sh_d      = {sh_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
               oe_d      = 1'b0;
               out_d     = 1'b1;
               state_d   = S_PRE;
               pre_cnt_d = '0;
            end
         end
         S_SKIP: begin
            if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
               state_d   = S_PRE;
               pre_cnt_d = '0;
            end
         end
         default: begin
            state_d   = S_PRE;
            pre_cnt_d = '0;
            oe_d      = 1'b0;
            out_d     = 1'b1;
         end
      endcase
   end

   assign mdio.mdio_out = out_q;
   assign mdio.mdio_oe  = oe_q;
   assign wr_strobe     = strobe_q;
   assign wr_addr       = waddr_q;
   assign wr_data       = wdata_q;
   assign frame_err     = ferr_q;

endmodule

// File: tb/tb_mdio_peripheral_regfile.sv
// Directed bench: three instances share clk/reset and the local port.
//   dut0: default parameters, dut1: NUM_REGS=8, dut2: PRE_LEN=0.
module tb_mdio_peripheral_regfile;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        loc_we;
   logic [4:0]  loc_addr;
   logic [15:0] loc_wdata;
   logic [4:0]  loc_raddr;

   logic [15:0] rdata0, rdata1, rdata2;
   logic        strobe0, strobe1, strobe2;
   logic [4:0]  waddr0, waddr1, waddr2;
   logic [15:0] wdata0, wdata1, wdata2;
   logic        ferr0, ferr1, ferr2;

   mdio_peripheral_regfile_if bus0 ();
   mdio_peripheral_regfile_if bus1 ();
   mdio_peripheral_regfile_if bus2 ();

   mdio_peripheral_regfile #(.PHY_ADDR(5'h01), .NUM_REGS(32), .PRE_LEN(32)) dut0 (
      .clk(clk), .reset(reset), .mdio(bus0),
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_raddr(loc_raddr), .loc_rdata(rdata0),
      .wr_strobe(strobe0), .wr_addr(waddr0), .wr_data(wdata0), .frame_err(ferr0));

   mdio_peripheral_regfile #(.PHY_ADDR(5'h01), .NUM_REGS(8), .PRE_LEN(32)) dut1 (
      .clk(clk), .reset(reset), .mdio(bus1),
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_raddr(loc_raddr), .loc_rdata(rdata1),
      .wr_strobe(strobe1), .wr_addr(waddr1), .wr_data(wdata1), .frame_err(ferr1));

   mdio_peripheral_regfile #(.PHY_ADDR(5'h01), .NUM_REGS(32), .PRE_LEN(0)) dut2 (
      .clk(clk), .reset(reset), .mdio(bus2),
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_raddr(loc_raddr), .loc_rdata(rdata2),
      .wr_strobe(strobe2), .wr_addr(waddr2), .wr_data(wdata2), .frame_err(ferr2));

   int checks = 0;
   int errors = 0;

   int str_cnt  [3] = '{0, 0, 0};
   int ferr_cnt [3] = '{0, 0, 0};
   int oe_cnt   [3] = '{0, 0, 0};

   always @(negedge clk) begin
      if (strobe0 === 1'b1) str_cnt[0]++;
      if (strobe1 === 1'b1) str_cnt[1]++;
      if (strobe2 === 1'b1) str_cnt[2]++;
      if (ferr0 === 1'b1) ferr_cnt[0]++;
      if (ferr1 === 1'b1) ferr_cnt[1]++;
      if (ferr2 === 1'b1) ferr_cnt[2]++;
      if (bus0.mdio_oe === 1'b1) oe_cnt[0]++;
      if (bus1.mdio_oe === 1'b1) oe_cnt[1]++;
      if (bus2.mdio_oe === 1'b1) oe_cnt[2]++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int d, input logic b);
      case (d)
         0:       bus0.mdio_in = b;
         1:       bus1.mdio_in = b;
         default: bus2.mdio_in = b;
      endcase
   endtask

   task automatic get_out(input int d, output logic o, output logic e);
      case (d)
         0:       begin o = bus0.mdio_out; e = bus0.mdio_oe; end
         1:       begin o = bus1.mdio_out; e = bus1.mdio_oe; end
         default: begin o = bus2.mdio_out; e = bus2.mdio_oe; end
      endcase
   endtask

   task automatic drive(input int d, input logic b);
      @(negedge clk);
      set_in(d, b);
   endtask

   task automatic send(input int d, input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) drive(d, v[i]);
   endtask

   task automatic pre(input int d, input int n);
      for (int i = 0; i < n; i++) drive(d, 1'b1);
   endtask

   task automatic hdr(input int d, input int npre, input logic [1:0] op,
                      input logic [4:0] phy, input logic [4:0] regad);
      pre(d, npre);
      send(d, 16'h0001, 2);
      send(d, {14'h0, op}, 2);
      send(d, {11'h0, phy}, 5);
      send(d, {11'h0, regad}, 5);
   endtask

   task automatic wr(input int d, input int npre, input logic [4:0] phy,
                     input logic [4:0] regad, input logic [15:0] data);
      hdr(d, npre, 2'b01, phy, regad);
      send(d, 16'h0002, 2);
      send(d, data, 16);
   endtask

   // Samples at the 19 negedges after REGAD[0] is driven: 1 = TA1, 2 = TA2,
   // 3..18 = DATA[15..0], 19 = first idle period.
   task automatic collect(input int d, output logic [15:0] data,
                          output int oe_n, output logic ta_ok);
      logic o, e;
      data = '0; oe_n = 0; ta_ok = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         get_out(d, o, e);
         set_in(d, 1'b1);
         if (e === 1'b1) oe_n++;
         if (k == 1 && e !== 1'b0) ta_ok = 1'b0;
         if (k == 2 && o !== 1'b0) ta_ok = 1'b0;
         if (k >= 3 && k <= 18) data = {data[14:0], o};
         if (k == 19 && (e !== 1'b0 || o !== 1'b1)) ta_ok = 1'b0;
      end
   endtask

   task automatic rd(input int d, input logic [4:0] regad, output logic [15:0] data,
                     output int oe_n, output logic ta_ok);
      hdr(d, 32, 2'b10, 5'h01, regad);
      collect(d, data, oe_n, ta_ok);
   endtask

   initial begin
      logic [15:0] rdv;
      int          oen;
      logic        tok;
      int          s, f, o;

      reset = 1'b0;
      bus0.mdio_in = 1'b1; bus1.mdio_in = 1'b1; bus2.mdio_in = 1'b1;
      loc_we = 1'b0; loc_addr = '0; loc_wdata = '0; loc_raddr = 5'd3;
      repeat (3) @(negedge clk);

      check("rst_oe",        32'(bus0.mdio_oe),  32'h0);
      check("rst_out",       32'(bus0.mdio_out), 32'h1);
      check("rst_strobe",    32'(strobe0),       32'h0);
      check("rst_wr_addr",   32'(waddr0),        32'h0);
      check("rst_wr_data",   32'(wdata0),        32'h0);
      check("rst_frame_err", 32'(ferr0),         32'h0);
      check("rst_bank",      32'(rdata0),        32'h0);
      reset = 1'b1;

      // write then read, default parameters
      s = str_cnt[0];
      wr(0, 32, 5'h01, 5'd3, 16'hA5C3);
      pre(0, 2);
      check("wr_strobe_cnt", 32'(str_cnt[0] - s), 32'd1);
      check("wr_addr",       32'(waddr0),         32'd3);
      check("wr_data",       32'(wdata0),         32'hA5C3);
      loc_raddr = 5'd3; #1;
      check("wr_bank",       32'(rdata0),         32'hA5C3);
      rd(0, 5'd3, rdv, oen, tok);
      check("rd_data",       32'(rdv),            32'hA5C3);
      check("rd_oe_cycles",  32'(oen),            32'd17);
      check("rd_ta_frame",   32'(tok),            32'h1);

      // address mismatch
      s = str_cnt[0]; o = oe_cnt[0];
      wr(0, 32, 5'h02, 5'd5, 16'hFFFF);
      pre(0, 2);
      check("mis_strobe",    32'(str_cnt[0] - s), 32'd0);
      check("mis_oe",        32'(oe_cnt[0] - o),  32'd0);
      loc_raddr = 5'd5; #1;
      check("mis_bank",      32'(rdata0),         32'h0);
      s = str_cnt[0];
      wr(0, 32, 5'h01, 5'd5, 16'h1234);
      pre(0, 2);
      check("mis_next_strobe", 32'(str_cnt[0] - s), 32'd1);
      check("mis_next_data",   32'(wdata0),         32'h1234);

      // bad ST, then bad OP
      f = ferr_cnt[0];
      pre(0, 32); send(0, 16'h0000, 2); pre(0, 2);
      check("bad_st_err",    32'(ferr_cnt[0] - f), 32'd1);
      f = ferr_cnt[0]; o = oe_cnt[0];
      pre(0, 32); send(0, 16'h0001, 2); send(0, 16'h0003, 2); pre(0, 2);
      check("bad_op_err",    32'(ferr_cnt[0] - f), 32'd1);
      check("bad_op_oe",     32'(oe_cnt[0] - o),   32'd0);
      rd(0, 5'd5, rdv, oen, tok);
      check("recover_rd",    32'(rdv),             32'h1234);

      // short preamble with PRE_LEN=32
      s = str_cnt[0];
      wr(0, 20, 5'h01, 5'd6, 16'hBEEF);
      pre(0, 2);
      check("short_pre_strobe", 32'(str_cnt[0] - s), 32'd0);
      loc_raddr = 5'd6; #1;
      check("short_pre_bank",   32'(rdata0),         32'h0);

      // PRE_LEN=0: back-to-back frames without preamble
      s = str_cnt[2];
      wr(2, 0, 5'h01, 5'd3, 16'h5A5A);
      wr(2, 0, 5'h01, 5'd4, 16'h0F0F);
      pre(2, 2);
      check("nopre_strobe",  32'(str_cnt[2] - s), 32'd2);
      check("nopre_addr",    32'(waddr2),         32'd4);
      check("nopre_data",    32'(wdata2),         32'h0F0F);

      // NUM_REGS=8: local write then MDIO read of it
      @(negedge clk); loc_we = 1'b1; loc_addr = 5'd1; loc_wdata = 16'h7777;
      @(negedge clk); loc_we = 1'b0;
      loc_raddr = 5'd1; #1;
      check("loc_wr_bank",   32'(rdata1),         32'h7777);
      rd(1, 5'd1, rdv, oen, tok);
      check("loc_wr_rd",     32'(rdv),            32'h7777);

      // local and MDIO write to REG 2 on the same edge
      s = str_cnt[1];
      wr(1, 32, 5'h01, 5'd2, 16'hC0DE);
      loc_we = 1'b1; loc_addr = 5'd2; loc_wdata = 16'h1111;
      @(negedge clk); loc_we = 1'b0;
      pre(1, 1);
      check("coll_strobe",   32'(str_cnt[1] - s), 32'd1);
      loc_raddr = 5'd2; #1;
      check("coll_bank",     32'(rdata1),         32'hC0DE);

      // out-of-range write and read
      s = str_cnt[1];
      wr(1, 32, 5'h01, 5'd10, 16'h4242);
      pre(1, 2);
      check("oor_wr_strobe", 32'(str_cnt[1] - s), 32'd0);
      loc_raddr = 5'd2; #1;
      check("oor_no_alias",  32'(rdata1),         32'hC0DE);
      rd(1, 5'd10, rdv, oen, tok);
      check("oor_rd_data",   32'(rdv),            32'h0);
      check("oor_rd_oe",     32'(oen),            32'd17);

      // reset during DATA bit 7 of a read
      hdr(0, 32, 2'b10, 5'h01, 5'd3);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); bus0.mdio_in = 1'b1;
      end
      @(negedge clk);
      check("mid_oe_before", 32'(bus0.mdio_oe),   32'h1);
      reset = 1'b0; #1;
      check("mid_oe_drop",   32'(bus0.mdio_oe),   32'h0);
      check("mid_out",       32'(bus0.mdio_out),  32'h1);
      loc_raddr = 5'd3; #1;
      check("mid_bank",      32'(rdata0),         32'h0);
      @(negedge clk); reset = 1'b1;
      rd(0, 5'd3, rdv, oen, tok);
      check("post_rst_rd",   32'(rdv),            32'h0);
      check("post_rst_oe",   32'(oen),            32'd17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
